// File: rtl/fifo_rr_merge.sv
// Round-robin merge of NUM_IN first-word-fall-through FIFO read sides into one
// write side, with bursts of up to MAX_BURST words per grant.
module fifo_rr_merge #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_empty_n,
  output logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic [SRC_WIDTH-1:0]         out_src,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        g, last, pick, cand;
  logic                    found;
  logic [CNT_W-1:0]        burst_cnt;
  logic [DATA_WIDTH-1:0]   words [NUM_IN];
  logic                    head_vld, ready, pop;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign words[i] = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitration: first valid input after the last one served, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_IN);
      if (!found && in_empty_n[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign head_vld = in_empty_n[g];
  assign ready    = ~out_write | out_full_n;
  assign pop      = (state == GRANT) & head_vld & ready;
  assign busy     = (state == GRANT);

  always_comb begin
    in_read    = '0;
    in_read[g] = pop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = GRANT;
      GRANT: if (!head_vld || (pop && burst_cnt == LAST_BEAT)) state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= IDX_W'(NUM_IN - 1);
      g         <= '0;
      burst_cnt <= '0;
      out_write <= 1'b0;
      out_din   <= '0;
      out_src   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        g         <= pick;
        burst_cnt <= '0;
      end
      if (state == GRANT && state_nxt == IDLE) last <= g;
      if (pop) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
        out_din   <= words[g];
        out_src   <= SRC_WIDTH'(g);
        out_write <= 1'b1;
      end else if (out_write && out_full_n) begin
        out_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Directed bench for fifo_rr_merge: behavioural FWFT sources, output capture,
// and per-scenario inline checks against hand-derived sequences.
module tb_fifo_rr_merge;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_empty_n, in_read;
  logic [N*W-1:0]   in_dout;
  logic             out_full_n, out_write, busy;
  logic [W-1:0]     out_din;
  logic [1:0]       out_src;

  logic             rst2_n, b_en;
  logic [N-1:0]     in_empty_n2, in_read2;
  logic [N*W-1:0]   in_dout2;
  logic             out_write2, busy2;
  logic [W-1:0]     out_din2;
  logic [1:0]       out_src2;

  int wr [N];
  int rd [N];
  int cyc, cap_n, cap2_n, proto_err;
  logic [1:0]  cap_src [512];
  logic [31:0] cap_dat [512];
  int          cap_cyc [512];
  logic [1:0]  cap2_src [64];
  logic [31:0] cap2_dat [64];
  int total, bad;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i, input int k);
    return {8'(8'hA0 + i), 24'(k)};
  endfunction

  fifo_rr_merge #(.NUM_IN(N), .DATA_WIDTH(W), .MAX_BURST(8), .SRC_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_empty_n(in_empty_n), .in_read(in_read),
    .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write),
    .out_din(out_din), .out_src(out_src), .busy(busy));

  fifo_rr_merge #(.NUM_IN(N), .DATA_WIDTH(W), .MAX_BURST(1), .SRC_WIDTH(2)) dut2 (
    .clk(clk), .reset(rst2_n), .in_empty_n(in_empty_n2), .in_read(in_read2),
    .in_dout(in_dout2), .out_full_n(1'b1), .out_write(out_write2),
    .out_din(out_din2), .out_src(out_src2), .busy(busy2));

  assign in_empty_n2 = b_en ? 4'b1001 : 4'b0000;
  assign in_dout2    = {word(3, 0), word(2, 0), word(1, 0), word(0, 0)};

  // FWFT source model: head word is a function of input index and read pointer
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_empty_n[i]       = (rd[i] < wr[i]);
      in_dout[i*W +: W]   = word(i, rd[i]);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      if (in_read[i]) rd[i] <= rd[i] + 1;
  end

  always @(negedge clk) begin
    if (out_write && out_full_n) begin
      cap_src[cap_n] <= out_src;
      cap_dat[cap_n] <= out_din;
      cap_cyc[cap_n] <= cyc;
      cap_n          <= cap_n + 1;
    end
    if (out_write2 && cap2_n < 64) begin
      cap2_src[cap2_n] <= out_src2;
      cap2_dat[cap2_n] <= out_din2;
      cap2_n           <= cap2_n + 1;
    end
    proto_err <= proto_err
               + (($countones(in_read) > 1 || (in_read & ~in_empty_n) != '0) ? 1 : 0)
               + (($countones(in_read2) > 1 || (in_read2 & ~in_empty_n2) != '0) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int n);
    wr[i] = wr[i] + n;
  endtask

  task automatic do_reset();
    out_full_n = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_caps(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      if (cap_n >= target) ok = 1'b1;
      else tick();
    end
    if (cap_n >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_full_n = 1'b1; rst2_n = 1'b0; b_en = 1'b0;
    tick(); tick();
    total++; if (out_write !== 1'b0) begin bad++; $display("FAIL rst_write: got %b want 0", out_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (in_read !== 4'b0) begin bad++; $display("FAIL rst_read: got %b want 0000", in_read); end
    total++; if (out_din !== 32'h0) begin bad++; $display("FAIL rst_din: got %h want 0", out_din); end
    total++; if (out_src !== 2'd0) begin bad++; $display("FAIL rst_src: got %0d want 0", out_src); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s;
    s = wr[2];
    load(2, 3);
    tick();
    total++; if (busy !== 1'b1 || out_write !== 1'b0) begin bad++; $display("FAIL single_arb: got busy=%b write=%b want 1 0", busy, out_write); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_write !== 1'b1 || out_din !== word(2, s + k) || out_src !== 2'd2) begin
        bad++; $display("FAIL single_word%0d: got w=%b d=%h s=%0d want 1 %h 2", k, out_write, out_din, out_src, word(2, s + k));
      end
    end
    tick();
    total++; if (out_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_end: got w=%b busy=%b want 0 0", out_write, busy); end
  endtask

  task automatic test_rotation();
    int s [N];
    int base, src, idx;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) s[i] = wr[i];
    base = cap_n;
    load(0, 16); load(1, 8); load(2, 8); load(3, 8);
    wait_caps(base + 40, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rot_timeout: got %0d words want 40", cap_n - base); end
    for (int k = 0; k < 40; k++) begin
      src = (k / 8) % 4;
      idx = (k < 32) ? (k % 8) : (8 + k - 32);
      total++; if (cap_src[base+k] !== 2'(src) || cap_dat[base+k] !== word(src, s[src] + idx)) begin
        bad++; $display("FAIL rot_word%0d: got src=%0d d=%h want src=%0d d=%h", k, cap_src[base+k], cap_dat[base+k], src, word(src, s[src] + idx));
      end
    end
    total++; if (cap_cyc[base+1] - cap_cyc[base] !== 1) begin bad++; $display("FAIL rot_b2b: got %0d want 1", cap_cyc[base+1] - cap_cyc[base]); end
    total++; if (cap_cyc[base+8] - cap_cyc[base+7] !== 2) begin bad++; $display("FAIL rot_gap: got %0d want 2", cap_cyc[base+8] - cap_cyc[base+7]); end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int s, base;
    bit ok;
    do_reset();
    s = wr[1];
    base = cap_n;
    load(1, 8);
    repeat (4) tick();
    total++; if (out_din !== word(1, s + 2)) begin bad++; $display("FAIL bp_pre: got %h want %h", out_din, word(1, s + 2)); end
    out_full_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (out_write !== 1'b1 || out_din !== word(1, s + 2)) begin bad++; $display("FAIL bp_hold%0d: got w=%b d=%h want 1 %h", c, out_write, out_din, word(1, s + 2)); end
      total++; if (in_read !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_read%0d: got rd=%b busy=%b want 0000 1", c, in_read, busy); end
      total++; if (dut.burst_cnt !== 4'd3) begin bad++; $display("FAIL bp_cnt%0d: got %0d want 3", c, dut.burst_cnt); end
    end
    out_full_n = 1'b1;
    tick();
    total++; if (out_din !== word(1, s + 3)) begin bad++; $display("FAIL bp_resume: got %h want %h", out_din, word(1, s + 3)); end
    wait_caps(base + 8, 100, ok);
    repeat (5) tick();
    total++; if (cap_n - base !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", cap_n - base); end
    for (int k = 0; k < 8; k++) begin
      total++; if (cap_src[base+k] !== 2'd1 || cap_dat[base+k] !== word(1, s + k)) begin
        bad++; $display("FAIL bp_word%0d: got src=%0d d=%h want 1 %h", k, cap_src[base+k], cap_dat[base+k], word(1, s + k));
      end
    end
  endtask

  task automatic test_empty_switch();
    int s [N];
    int exp_src [7] = '{1, 1, 1, 2, 2, 0, 0};
    int exp_off [7] = '{0, 1, 2, 0, 1, 0, 1};
    int base, src;
    bit ok;
    do_reset();
    load(0, 1);
    repeat (6) tick();
    for (int i = 0; i < N; i++) s[i] = wr[i];
    base = cap_n;
    load(0, 2); load(1, 3); load(2, 2);
    wait_caps(base + 7, 100, ok);
    repeat (5) tick();
    total++; if (cap_n - base !== 7) begin bad++; $display("FAIL sw_count: got %0d want 7", cap_n - base); end
    for (int k = 0; k < 7; k++) begin
      src = exp_src[k];
      total++; if (cap_src[base+k] !== 2'(src) || cap_dat[base+k] !== word(src, s[src] + exp_off[k])) begin
        bad++; $display("FAIL sw_word%0d: got src=%0d d=%h want src=%0d d=%h", k, cap_src[base+k], cap_dat[base+k], src, word(src, s[src] + exp_off[k]));
      end
    end
    total++; if (rd[1] !== s[1] + 3) begin bad++; $display("FAIL sw_rd1: got %0d want %0d", rd[1], s[1] + 3); end
  endtask

  task automatic test_burst1();
    int base2, src;
    rst2_n = 1'b1;
    tick();
    base2 = cap2_n;
    b_en = 1'b1;
    for (int c = 0; c < 40 && cap2_n < base2 + 4; c++) tick();
    b_en = 1'b0;
    total++; if (cap2_n < base2 + 4) begin bad++; $display("FAIL b1_timeout: got %0d words want 4", cap2_n - base2); end
    for (int k = 0; k < 4; k++) begin
      src = (k % 2 == 0) ? 0 : 3;
      total++; if (cap2_src[base2+k] !== 2'(src) || cap2_dat[base2+k] !== word(src, 0)) begin
        bad++; $display("FAIL b1_word%0d: got src=%0d d=%h want src=%0d d=%h", k, cap2_src[base2+k], cap2_dat[base2+k], src, word(src, 0));
      end
    end
    repeat (3) tick();
    rst2_n = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0, s2, base;
    bit ok;
    do_reset();
    s2 = wr[2];
    base = cap_n;
    load(2, 4);
    tick(); tick();
    total++; if (out_write !== 1'b1 || out_din !== word(2, s2)) begin bad++; $display("FAIL rm_pre: got w=%b d=%h want 1 %h", out_write, out_din, word(2, s2)); end
    out_full_n = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_async: got w=%b busy=%b want 0 0", out_write, busy); end
    total++; if (out_din !== 32'h0 || in_read !== 4'b0) begin bad++; $display("FAIL rm_clear: got d=%h rd=%b want 0 0000", out_din, in_read); end
    s0 = wr[0];
    load(0, 1);
    tick();
    total++; if (out_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_held: got w=%b busy=%b want 0 0", out_write, busy); end
    out_full_n = 1'b1;
    reset = 1'b1;
    wait_caps(base + 4, 100, ok);
    repeat (5) tick();
    total++; if (cap_n - base !== 4) begin bad++; $display("FAIL rm_count: got %0d want 4", cap_n - base); end
    total++; if (cap_src[base] !== 2'd0 || cap_dat[base] !== word(0, s0)) begin
      bad++; $display("FAIL rm_first: got src=%0d d=%h want 0 %h", cap_src[base], cap_dat[base], word(0, s0));
    end
    for (int k = 1; k < 4; k++) begin
      total++; if (cap_src[base+k] !== 2'd2 || cap_dat[base+k] !== word(2, s2 + k)) begin
        bad++; $display("FAIL rm_word%0d: got src=%0d d=%h want 2 %h", k, cap_src[base+k], cap_dat[base+k], word(2, s2 + k));
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (proto_err !== 0) begin bad++; $display("FAIL protocol: got %0d bad pops want 0", proto_err); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_empty_switch();
    test_burst1();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_merge.md
FIFO_RR_MERGE -- requirements
Module: fifo_rr_merge

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of FWFT FIFO read sides merged (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, max consecutive words granted to one input (>=1).
REQ-004 SHALL have parameter SRC_WIDTH, default 2, width of source tag (>= clog2(NUM_IN)).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port in_empty_n  input  NUM_IN  per-input FWFT data-valid (FIFO if_empty_n).
REQ-008 SHALL have port in_read  output  NUM_IN  per-input consume strobe (drives FIFO if_read).
REQ-009 SHALL have port in_dout  input  NUM_IN*DATA_WIDTH  packed head words, input i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_full_n  input  1  downstream write-side ready (FIFO if_full_n).
REQ-011 SHALL have port out_write  output  1  output word valid (drives FIFO if_write).
REQ-012 SHALL have port out_din  output  DATA_WIDTH  output word.
REQ-013 SHALL have port out_src  output  SRC_WIDTH  index of input that supplied out_din.
REQ-014 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-015 SHALL implement two states: IDLE (no grant) and GRANT (grant index g held in a register).
REQ-016 SHALL, in IDLE, select g as the first i with in_empty_n[i]=1 searching (last+1) upward with wrap NUM_IN-1->0, register it, clear burst_cnt, and enter GRANT next cycle; stay IDLE if none valid.
REQ-017 SHALL define ready = ~out_write | out_full_n and pop = (state==GRANT) & in_empty_n[g] & ready.
REQ-018 SHALL drive in_read combinationally: in_read[g]=pop, all other bits 0; in_read SHALL be all-zero in IDLE.
REQ-019 SHALL, on pop, load out_din<=in_dout slice g, out_src<=g, out_write<=1, burst_cnt<=burst_cnt+1.
REQ-020 SHALL, when out_write=1 & out_full_n=1 & no pop, clear out_write; when out_write=1 & out_full_n=0, hold out_write/out_din/out_src unchanged.
REQ-021 SHALL leave GRANT for IDLE, setting last<=g, when pop occurs with burst_cnt==MAX_BURST-1, or when in_empty_n[g]=0.
REQ-022 SHALL remain in GRANT without popping while in_empty_n[g]=1 and ready=0 (backpressure does not forfeit grant or burst count).
REQ-023 SHALL sustain one word per cycle within a burst while ready=1.
REQ-024 SHALL have latency of 2 cycles from in_empty_n[i] rising (all others idle, state IDLE) to out_write=1: cycle 0 arbitrate, cycle 1 pop, cycle 2 out_write.
REQ-025 SHALL size burst_cnt as clog2(MAX_BURST+1) bits; MAX_BURST=1 rotates after every word.
REQ-026 SHALL never pop a word that is not valid, never pop two inputs in one cycle, and never drop or duplicate a word.
REQ-027 SHALL rely on out_full_n being a grace-margin almost-full signal; no additional skid storage is required.

Reset
REQ-028 SHALL, while reset=0, asynchronously force: state=IDLE, last=NUM_IN-1 (first search starts at input 0), g=0, burst_cnt=0, out_write=0, out_din=0, out_src=0; in_read=0 and busy=0 follow.
REQ-029 SHALL discard any word held in the output register on reset assertion mid-operation; inputs not yet popped remain untouched.
REQ-030 SHALL leave reset synchronously-released behaviour to the integrator; first arbitration occurs on the first rising edge with reset=1.

Verification
REQ-031 Single input: in_empty_n=4'b0100, 3 words A,B,C, out_full_n=1 -> out_write first high cycle 2, out_din A,B,C back-to-back, out_src=2, busy drops after C.
REQ-032 All four inputs continuously valid, MAX_BURST=8, out_full_n=1 -> out_src sequence 0x8,1x8,2x8,3x8,0x8..., one IDLE gap cycle per rotation.
REQ-033 Backpressure: mid-burst hold out_full_n=0 for 5 cycles -> out_write/out_din stable, in_read all zero, burst_cnt unchanged, resume with next word, no loss.
REQ-034 Input 1 empties after 3 of 8 words while inputs 0,2 valid, last=0 -> grant moves to input 2 next, then 0; input 1 gets no further pops until valid.
REQ-035 MAX_BURST=1, inputs 0 and 3 valid -> out_src alternates 0,3,0,3.
REQ-036 Reset asserted while out_write=1, out_full_n=0 -> out_write=0 immediately (asynchronous), state IDLE, first grant after release is input 0 if valid.
